// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared state type, default widths and timeout counter sizing for the MEM stage
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int unsigned DEF_DATA_W         = 24;
    localparam int unsigned DEF_ADDR_W         = 24;
    localparam int unsigned DEF_DEST_W         = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

    // The timeout counter only needs to reach TIMEOUT_CYCLES-1, so it never holds TIMEOUT_CYCLES itself
    function automatic int unsigned timeout_cnt_w(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// rtl/mem_bus_fsm.sv - req/ack bus sequencer: state, bus output registers, read data, error flag (MEM_TIMEOUT_EN adds abort counter)
module mem_bus_fsm
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read_en,
    input  logic              i_write_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output mem_state_t        o_state,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_error
);

    if (ADDR_W > DATA_W || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mem_bus_fsm: ADDR_W must not exceed DATA_W and TIMEOUT_CYCLES must be at least 1");
    end

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_error;

    logic w_access;
    logic w_issue;
    logic w_complete;
    logic w_abort;
    logic w_timeout_hit;
    logic w_err_set;

    assign w_access = i_read_en | i_write_en;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = timeout_cnt_w(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    // Count BUSY cycles since the request was issued; abort on the last allowed one
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= '0;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; an ack wins over a timeout landing in the same cycle
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_issue      = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (i_mem_ack) begin
                    w_complete   = 1'b1;
                    w_state_next = DONE;
                end else if (w_timeout_hit) begin
                    w_abort      = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Conflicting read+write at issue, an ack outside BUSY, or a timeout all latch the sticky error
    assign w_err_set = (w_issue & i_read_en & i_write_en)
                     | (i_mem_ack & (r_state != BUSY))
                     | w_abort;

    // Bus output registers, captured read data and error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_error     <= 1'b0;
        end else begin
            if (w_issue) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= i_write_en;
                r_mem_addr  <= i_addr;
                r_mem_wdata <= i_wdata;
            end
            if (w_complete) begin
                r_mem_req <= 1'b0;
                if (!r_mem_we) begin
                    r_rdata <= i_mem_rdata;
                end
            end
            if (w_abort) begin
                r_mem_req <= 1'b0;
                r_rdata   <= '0;
            end
            if (w_err_set) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_state     = r_state;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_rdata     = r_rdata;
    assign o_error     = r_error;

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: bus access, stall generation and writeback muxing (MEM_TIMEOUT_EN enables BUSY abort)
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DEST_W         = DEF_DEST_W,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writeback_enable,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    input  logic [DEST_W-1:0] instruction_dest,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] write_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_out,
    output logic              writeback_enable_out,
    output logic [DEST_W-1:0] instruction_dest_out,
    output logic [DATA_W-1:0] writeback_data_out,
    output logic              mem_error_out
);

    mem_state_t        w_state;
    logic [DATA_W-1:0] w_rdata;
    logic              w_access;
    logic              w_stall;
    logic [DATA_W-1:0] w_wb_data;

    assign w_access = mem_read_enable | mem_write_enable;

    mem_bus_fsm #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_read_en   (mem_read_enable),
        .i_write_en  (mem_write_enable),
        .i_addr      (alu_result[ADDR_W-1:0]),
        .i_wdata     (write_data),
        .i_mem_rdata (mem_rdata),
        .i_mem_ack   (mem_ack),
        .o_state     (w_state),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_rdata     (w_rdata),
        .o_error     (mem_error_out)
    );

    // Stall while an access is pending; in DONE a load returns captured data (mem_we still holds the op type)
    always_comb begin
        w_stall   = 1'b0;
        w_wb_data = alu_result;
        case (w_state)
            IDLE: w_stall = w_access;
            BUSY: w_stall = 1'b1;
            DONE: begin
                if (!mem_we) begin
                    w_wb_data = w_rdata;
                end
            end
            default: w_stall = 1'b0;
        endcase
    end

    // Reset releases the upstream pipeline immediately, even with an access still presented
    assign stall_out            = rst & w_stall;
    assign writeback_data_out   = w_wb_data;
    assign writeback_enable_out = writeback_enable;
    assign instruction_dest_out = instruction_dest;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
`timescale 1ns/1ps
module tb_mem_access_stage;

    localparam int DATA_W = 24;
    localparam int ADDR_W = 24;
    localparam int DEST_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              writeback_enable;
    logic              mem_read_enable;
    logic              mem_write_enable;
    logic [DEST_W-1:0] instruction_dest;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall_out;
    logic              writeback_enable_out;
    logic [DEST_W-1:0] instruction_dest_out;
    logic [DATA_W-1:0] writeback_data_out;
    logic              mem_error_out;

    int vectors     = 0;
    int miscompares = 0;
    int req_rises   = 0;

    mem_access_stage #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .DEST_W         (DEST_W),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .writeback_enable     (writeback_enable),
        .mem_read_enable      (mem_read_enable),
        .mem_write_enable     (mem_write_enable),
        .instruction_dest     (instruction_dest),
        .alu_result           (alu_result),
        .write_data           (write_data),
        .mem_req              (mem_req),
        .mem_we               (mem_we),
        .mem_addr             (mem_addr),
        .mem_wdata            (mem_wdata),
        .mem_rdata            (mem_rdata),
        .mem_ack              (mem_ack),
        .stall_out            (stall_out),
        .writeback_enable_out (writeback_enable_out),
        .instruction_dest_out (instruction_dest_out),
        .writeback_data_out   (writeback_data_out),
        .mem_error_out        (mem_error_out)
    );

    always #5 clk = ~clk;

    always @(posedge mem_req) req_rises++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        writeback_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        instruction_dest = '0;
        alu_result       = '0;
        write_data       = '0;
        mem_rdata        = '0;
        mem_ack          = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst        = 1'b0;
        alu_result = 24'h123456;
        tick();
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", mem_req); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", mem_we); end
        vectors++; if (mem_addr !== 24'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 000000", mem_addr); end
        vectors++; if (mem_wdata !== 24'h0) begin miscompares++; $display("FAIL reset_wdata: got %h want 000000", mem_wdata); end
        vectors++; if (mem_error_out !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", mem_error_out); end
        vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall_out); end
        vectors++; if (writeback_data_out !== 24'h123456) begin miscompares++; $display("FAIL reset_wb: got %h want 123456", writeback_data_out); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_alu_op();
        int rises0;
        rises0 = req_rises;
        writeback_enable = 1'b1;
        instruction_dest = 4'd2;
        alu_result       = 24'd5;
        #1;
        vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL alu_stall: got %b want 0", stall_out); end
        vectors++; if (writeback_data_out !== 24'd5) begin miscompares++; $display("FAIL alu_wb: got %h want 000005", writeback_data_out); end
        vectors++; if (writeback_enable_out !== 1'b1) begin miscompares++; $display("FAIL alu_wben: got %b want 1", writeback_enable_out); end
        vectors++; if (instruction_dest_out !== 4'd2) begin miscompares++; $display("FAIL alu_dest: got %0d want 2", instruction_dest_out); end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (mem_req !== 1'b0 || stall_out !== 1'b0) begin miscompares++; $display("FAIL alu_nobus: req %b stall %b want 0 0", mem_req, stall_out); end
        end
        vectors++; if (req_rises !== rises0) begin miscompares++; $display("FAIL alu_rises: got %0d want %0d", req_rises, rises0); end
        idle_inputs();
        tick();
    endtask

    task automatic test_load();
        int stalls;
        stalls           = 0;
        writeback_enable = 1'b1;
        instruction_dest = 4'd7;
        mem_read_enable  = 1'b1;
        alu_result       = 24'h000010;
        #1;
        if (stall_out === 1'b1) stalls++;
        tick();
        if (stall_out === 1'b1) stalls++;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL load_req: got %b want 1", mem_req); end
        vectors++; if (mem_addr !== 24'h000010) begin miscompares++; $display("FAIL load_addr: got %h want 000010", mem_addr); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL load_we: got %b want 0", mem_we); end
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 24'h00ABCD;
        #1;
        if (stall_out === 1'b1) stalls++;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL load_req_held: got %b want 1", mem_req); end
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 24'h0;
        #1;
        vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL load_done_stall: got %b want 0", stall_out); end
        vectors++; if (writeback_data_out !== 24'h00ABCD) begin miscompares++; $display("FAIL load_wb: got %h want 00abcd", writeback_data_out); end
        vectors++; if (instruction_dest_out !== 4'd7) begin miscompares++; $display("FAIL load_dest: got %0d want 7", instruction_dest_out); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL load_req_drop: got %b want 0", mem_req); end
        vectors++; if (stalls !== 3) begin miscompares++; $display("FAIL load_stall_cycles: got %0d want 3", stalls); end
        vectors++; if (mem_error_out !== 1'b0) begin miscompares++; $display("FAIL load_err: got %b want 0", mem_error_out); end
        idle_inputs();
        tick();
    endtask

    task automatic test_store();
        int stalls;
        stalls           = 0;
        mem_write_enable = 1'b1;
        alu_result       = 24'h000020;
        write_data       = 24'd10;
        #1;
        if (stall_out === 1'b1) stalls++;
        tick();
        mem_ack = 1'b1;
        #1;
        if (stall_out === 1'b1) stalls++;
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL store_we: got %b want 1", mem_we); end
        vectors++; if (mem_wdata !== 24'd10) begin miscompares++; $display("FAIL store_wdata: got %h want 00000a", mem_wdata); end
        vectors++; if (mem_addr !== 24'h000020) begin miscompares++; $display("FAIL store_addr: got %h want 000020", mem_addr); end
        tick();
        mem_ack = 1'b0;
        #1;
        vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL store_done_stall: got %b want 0", stall_out); end
        vectors++; if (writeback_data_out !== 24'h000020) begin miscompares++; $display("FAIL store_wb: got %h want 000020", writeback_data_out); end
        vectors++; if (stalls !== 2) begin miscompares++; $display("FAIL store_stall_cycles: got %0d want 2", stalls); end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        int rises0;
        rises0          = req_rises;
        mem_read_enable = 1'b1;
        alu_result      = 24'h000001;
        tick();
        vectors++; if (mem_addr !== 24'h000001) begin miscompares++; $display("FAIL b2b_addr1: got %h want 000001", mem_addr); end
        mem_ack   = 1'b1;
        mem_rdata = 24'd7;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 24'd0;
        #1;
        vectors++; if (writeback_data_out !== 24'd7) begin miscompares++; $display("FAIL b2b_wb1: got %h want 000007", writeback_data_out); end
        vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL b2b_done1_stall: got %b want 0", stall_out); end
        tick();
        alu_result = 24'h000002;
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL b2b_no_req_in_done: got %b want 0", mem_req); end
        vectors++; if (stall_out !== 1'b1) begin miscompares++; $display("FAIL b2b_idle2_stall: got %b want 1", stall_out); end
        tick();
        vectors++; if (mem_req !== 1'b1 || mem_addr !== 24'h000002) begin miscompares++; $display("FAIL b2b_req2: req %b addr %h want 1 000002", mem_req, mem_addr); end
        mem_ack   = 1'b1;
        mem_rdata = 24'd9;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 24'd0;
        #1;
        vectors++; if (writeback_data_out !== 24'd9) begin miscompares++; $display("FAIL b2b_wb2: got %h want 000009", writeback_data_out); end
        vectors++; if (req_rises - rises0 !== 2) begin miscompares++; $display("FAIL b2b_req_count: got %0d want 2", req_rises - rises0); end
        idle_inputs();
        tick();
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int busy_cycles;
        busy_cycles     = 0;
        mem_read_enable = 1'b1;
        alu_result      = 24'h000040;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (mem_req !== 1'b1) break;
            busy_cycles++;
            tick();
        end
        vectors++; if (busy_cycles !== 4) begin miscompares++; $display("FAIL timeout_busy_cycles: got %0d want 4", busy_cycles); end
        vectors++; if (mem_error_out !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %b want 1", mem_error_out); end
        vectors++; if (writeback_data_out !== 24'h0) begin miscompares++; $display("FAIL timeout_wb: got %h want 000000", writeback_data_out); end
        vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL timeout_stall: got %b want 0", stall_out); end
        idle_inputs();
        tick();
    endtask
`endif

    task automatic test_reset_mid_busy();
        int rises0;
        rst             = 1'b0;
        tick();
        rst             = 1'b1;
        tick();
        mem_read_enable = 1'b1;
        alu_result      = 24'h000050;
        tick();
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rstbusy_req_before: got %b want 1", mem_req); end
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rstbusy_req_async: got %b want 0", mem_req); end
        vectors++; if (stall_out !== 1'b0) begin miscompares++; $display("FAIL rstbusy_stall_async: got %b want 0", stall_out); end
        tick();
        mem_read_enable = 1'b0;
        rst             = 1'b1;
        rises0          = req_rises;
        mem_ack         = 1'b1;
        mem_rdata       = 24'h00FFFF;
        tick();
        mem_ack         = 1'b0;
        #1;
        vectors++; if (mem_req !== 1'b0 || stall_out !== 1'b0) begin miscompares++; $display("FAIL late_ack_ignored: req %b stall %b want 0 0", mem_req, stall_out); end
        vectors++; if (mem_error_out !== 1'b1) begin miscompares++; $display("FAIL late_ack_err: got %b want 1", mem_error_out); end
        vectors++; if (req_rises !== rises0) begin miscompares++; $display("FAIL late_ack_rises: got %0d want %0d", req_rises, rises0); end
        idle_inputs();
        tick();
    endtask

    task automatic test_read_write_conflict();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        vectors++; if (mem_error_out !== 1'b0) begin miscompares++; $display("FAIL conflict_err_cleared: got %b want 0", mem_error_out); end
        mem_read_enable  = 1'b1;
        mem_write_enable = 1'b1;
        alu_result       = 24'h000030;
        write_data       = 24'h000055;
        tick();
        vectors++; if (mem_we !== 1'b1 || mem_wdata !== 24'h000055) begin miscompares++; $display("FAIL conflict_write: we %b wdata %h want 1 000055", mem_we, mem_wdata); end
        vectors++; if (mem_error_out !== 1'b1) begin miscompares++; $display("FAIL conflict_err: got %b want 1", mem_error_out); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        vectors++; if (writeback_data_out !== 24'h000030) begin miscompares++; $display("FAIL conflict_wb: got %h want 000030", writeback_data_out); end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_load();
        test_store();
        test_back_to_back();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_busy();
        test_read_write_conflict();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
